sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_flags.sv | 171 +++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO backed by a register array, with an occupancy count,
// programmable almost-full/almost-empty thresholds, one-cycle overflow and
// underflow error pulses, and a choice of standard (1-cycle read latency)
// or first-word-fall-through read behaviour.
//
// Ports
//   Clk             : clock, all state updates on the rising edge
//   Clear_in        : synchronous active-high reset / flush (highest priority)
//   Data_in         : write data
//   WriteEn_in      : write request, accepted when not full
//   Full_out        : count == FIFO_DEPTH
//   AlmostFull_out  : count >= ALMOST_FULL_THRESH
//   Overflow_out    : pulse, previous cycle had a write request while full
//   ReadEn_in       : read request (pop/acknowledge in FWFT mode)
//   Data_out        : read data
//   Valid_out       : standard mode: Data_out freshly popped;
//                     FWFT mode: ~Empty_out
//   Empty_out       : count == 0
//   AlmostEmpty_out : count <= ALMOST_EMPTY_THRESH
//   Underflow_out   : pulse, previous cycle had a read request while empty
//   Count_out       : current occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int DATA_WIDTH          = 8,
    parameter int ADDRESS_WIDTH       = 4,
    parameter int FIFO_DEPTH          = (1 << ADDRESS_WIDTH),
    parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESH = 2,
    parameter int FWFT                = 0
) (
    input  logic                     Clk,
    input  logic                     Clear_in,
    input  logic [DATA_WIDTH-1:0]    Data_in,
    input  logic                     WriteEn_in,
    output logic                     Full_out,
    output logic                     AlmostFull_out,
    output logic                     Overflow_out,
    input  logic                     ReadEn_in,
    output logic [DATA_WIDTH-1:0]    Data_out,
    output logic                     Valid_out,
    output logic                     Empty_out,
    output logic                     AlmostEmpty_out,
    output logic                     Underflow_out,
    output logic [ADDRESS_WIDTH:0]   Count_out
);

    localparam logic [ADDRESS_WIDTH:0] DEPTH_C = FIFO_DEPTH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] AF_C    = ALMOST_FULL_THRESH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] AE_C    = ALMOST_EMPTY_THRESH[ADDRESS_WIDTH:0];

    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];

    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_WIDTH:0]   count_q,  count_d;
    logic                     full_q,   full_d;
    logic                     afull_q,  afull_d;
    logic                     empty_q,  empty_d;
    logic                     aempty_q, aempty_d;
    logic                     ovf_q,    ovf_d;
    logic                     udf_q,    udf_d;
    logic                     valid_q,  valid_d;
    logic [DATA_WIDTH-1:0]    rdata_q,  rdata_d;

    logic                     wr_accept_s;
    logic                     rd_accept_s;
    logic [DATA_WIDTH-1:0]    head_s;

    // Accept decisions and next-state for pointers, count, flags and read data
    always_comb begin
        // Acceptance uses the registered flags, so there is no pass-through
        // on empty and no write slot freed by a same-cycle read on full.
        wr_accept_s = WriteEn_in & ~full_q;
        rd_accept_s = ReadEn_in  & ~empty_q;
        head_s      = mem_q[rd_ptr_q];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;

        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_accept_s) begin
            rd_ptr_d = rd_ptr_q + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
            rdata_d  = head_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
            rdata_d  = rdata_q;
        end

        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_d = count_q + {{ADDRESS_WIDTH{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{ADDRESS_WIDTH{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        // Flags come from the next count so they are exact right after the edge.
        full_d   = (count_d == DEPTH_C);
        afull_d  = (count_d >= AF_C);
        empty_d  = (count_d == {(ADDRESS_WIDTH+1){1'b0}});
        aempty_d = (count_d <= AE_C);

        ovf_d    = WriteEn_in & full_q;
        udf_d    = ReadEn_in  & empty_q;
        valid_d  = rd_accept_s;
    end

    // Control and status registers with synchronous clear
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            wr_ptr_q <= {ADDRESS_WIDTH{1'b0}};
            rd_ptr_q <= {ADDRESS_WIDTH{1'b0}};
            count_q  <= {(ADDRESS_WIDTH+1){1'b0}};
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            valid_q  <= 1'b0;
            rdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage array; deliberately not cleared, a flush only resets pointers
    always_ff @(posedge Clk) begin
        if (wr_accept_s && !Clear_in) begin
            mem_q[wr_ptr_q] <= Data_in;
        end
    end

    // Output mapping; in FWFT mode the head word is shown while non-empty and
    // forced to zero when empty so the post-clear value is deterministic.
    always_comb begin
        if (FWFT != 0) begin
            Data_out  = empty_q ? {DATA_WIDTH{1'b0}} : head_s;
            Valid_out = ~empty_q;
        end else begin
            Data_out  = rdata_q;
            Valid_out = valid_q;
        end
        Full_out        = full_q;
        AlmostFull_out  = afull_q;
        Overflow_out    = ovf_q;
        Empty_out       = empty_q;
        AlmostEmpty_out = aempty_q;
        Underflow_out   = udf_q;
        Count_out       = count_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
//
// Directed self-checking bench. Two instances share the stimulus: one in
// standard read mode (default parameters, depth 16) and one in FWFT mode.
// Inputs are driven 1 time unit after a rising edge, outputs are sampled at
// the same point, so each step() shows the result of one clock edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

    logic       clk;
    logic       clear;
    logic [7:0] din;
    logic       we;
    logic       re;

    logic       s_full, s_afull, s_ovf, s_valid, s_empty, s_aempty, s_udf;
    logic [7:0] s_dout;
    logic [4:0] s_count;

    logic       f_full, f_afull, f_ovf, f_valid, f_empty, f_aempty, f_udf;
    logic [7:0] f_dout;
    logic [4:0] f_count;

    int errors = 0;
    int checks = 0;

    sync_fifo_flags #(.FWFT(0)) dut_std (
        .Clk(clk), .Clear_in(clear), .Data_in(din), .WriteEn_in(we),
        .Full_out(s_full), .AlmostFull_out(s_afull), .Overflow_out(s_ovf),
        .ReadEn_in(re), .Data_out(s_dout), .Valid_out(s_valid),
        .Empty_out(s_empty), .AlmostEmpty_out(s_aempty),
        .Underflow_out(s_udf), .Count_out(s_count)
    );

    sync_fifo_flags #(.FWFT(1)) dut_fwft (
        .Clk(clk), .Clear_in(clear), .Data_in(din), .WriteEn_in(we),
        .Full_out(f_full), .AlmostFull_out(f_afull), .Overflow_out(f_ovf),
        .ReadEn_in(re), .Data_out(f_dout), .Valid_out(f_valid),
        .Empty_out(f_empty), .AlmostEmpty_out(f_aempty),
        .Underflow_out(f_udf), .Count_out(f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;
    endtask

    task automatic test_reset();
        clear = 1'b1; we = 1'b1; re = 1'b0; din = 8'h77;
        step();
        step();
        checks++; if (s_count !== 5'd0)  begin errors++; $display("FAIL reset_count got=%0d exp=0", s_count); end
        checks++; if (s_empty !== 1'b1)  begin errors++; $display("FAIL reset_empty got=%b exp=1", s_empty); end
        checks++; if (s_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got=%b exp=1", s_aempty); end
        checks++; if (s_full !== 1'b0)   begin errors++; $display("FAIL reset_full got=%b exp=0", s_full); end
        checks++; if (s_afull !== 1'b0)  begin errors++; $display("FAIL reset_afull got=%b exp=0", s_afull); end
        checks++; if (s_ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got=%b exp=0", s_ovf); end
        checks++; if (s_udf !== 1'b0)    begin errors++; $display("FAIL reset_udf got=%b exp=0", s_udf); end
        checks++; if (s_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
        checks++; if (s_dout !== 8'h00)  begin errors++; $display("FAIL reset_dout got=%h exp=00", s_dout); end
        checks++; if (f_valid !== 1'b0)  begin errors++; $display("FAIL reset_fwft_valid got=%b exp=0", f_valid); end
        checks++; if (f_dout !== 8'h00)  begin errors++; $display("FAIL reset_fwft_dout got=%h exp=00", f_dout); end
        idle();
        step();
        checks++; if (s_empty !== 1'b1)  begin errors++; $display("FAIL reset_nothing_stored got=%b exp=1", s_empty); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; din = 8'(i);
            step();
            checks++; if (s_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, s_count, i + 1); end
            checks++; if (s_afull !== ((i + 1) >= 14)) begin errors++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, s_afull, (i + 1) >= 14); end
            checks++; if (s_full !== ((i + 1) == 16)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, s_full, (i + 1) == 16); end
            checks++; if (s_aempty !== ((i + 1) <= 2)) begin errors++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", i, s_aempty, (i + 1) <= 2); end
        end
        // 17th write while full
        we = 1'b1; din = 8'hEE;
        step();
        checks++; if (s_ovf !== 1'b1)    begin errors++; $display("FAIL ovf_pulse got=%b exp=1", s_ovf); end
        checks++; if (s_count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", s_count); end
        idle();
        step();
        checks++; if (s_ovf !== 1'b0)    begin errors++; $display("FAIL ovf_single got=%b exp=0", s_ovf); end
        // read + write at full: only the read is taken
        we = 1'b1; re = 1'b1; din = 8'hEE;
        step();
        checks++; if (s_ovf !== 1'b1)    begin errors++; $display("FAIL full_rw_ovf got=%b exp=1", s_ovf); end
        checks++; if (s_count !== 5'd15) begin errors++; $display("FAIL full_rw_count got=%0d exp=15", s_count); end
        checks++; if (s_dout !== 8'h00)  begin errors++; $display("FAIL full_rw_dout got=%h exp=00", s_dout); end
        checks++; if (s_valid !== 1'b1)  begin errors++; $display("FAIL full_rw_valid got=%b exp=1", s_valid); end
        checks++; if (s_full !== 1'b0)   begin errors++; $display("FAIL full_rw_full got=%b exp=0", s_full); end
        we = 1'b0;
        for (int i = 1; i < 16; i++) begin
            re = 1'b1;
            step();
            checks++; if (s_dout !== 8'(i))   begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, s_dout, 8'(i)); end
            checks++; if (s_valid !== 1'b1)   begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, s_valid); end
            checks++; if (s_count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, s_count, 15 - i); end
        end
        idle();
        step();
        checks++; if (s_valid !== 1'b0)  begin errors++; $display("FAIL drain_valid_end got=%b exp=0", s_valid); end
        checks++; if (s_empty !== 1'b1)  begin errors++; $display("FAIL drain_empty got=%b exp=1", s_empty); end
        checks++; if (s_dout !== 8'h0F)  begin errors++; $display("FAIL drain_hold got=%h exp=0f", s_dout); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; din = 8'(8'h50 + i);
            step();
        end
        checks++; if (s_count !== 5'd5) begin errors++; $display("FAIL wrap_prefill got=%0d exp=5", s_count); end
        for (int i = 0; i < 40; i++) begin
            we = 1'b1; re = 1'b1; din = 8'(8'h55 + i);
            step();
            checks++; if (s_dout !== 8'(8'h50 + i)) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, s_dout, 8'(8'h50 + i)); end
            checks++; if (s_count !== 5'd5 || s_valid !== 1'b1) begin errors++; $display("FAIL wrap_count[%0d] got=%0d/%b exp=5/1", i, s_count, s_valid); end
            checks++; if ({s_full, s_afull, s_empty, s_aempty} !== 4'b0000) begin errors++; $display("FAIL wrap_flags[%0d] got=%b exp=0000", i, {s_full, s_afull, s_empty, s_aempty}); end
        end
        we = 1'b0;
        for (int j = 0; j < 5; j++) begin
            re = 1'b1;
            step();
            checks++; if (s_dout !== 8'(8'h78 + j)) begin errors++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", j, s_dout, 8'(8'h78 + j)); end
        end
        idle();
        step();
    endtask

    task automatic test_underflow();
        re = 1'b1;
        step();
        checks++; if (s_udf !== 1'b1)   begin errors++; $display("FAIL udf_pulse got=%b exp=1", s_udf); end
        checks++; if (s_dout !== 8'h7C) begin errors++; $display("FAIL udf_dout_hold got=%h exp=7c", s_dout); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL udf_valid got=%b exp=0", s_valid); end
        idle();
        step();
        checks++; if (s_udf !== 1'b0)   begin errors++; $display("FAIL udf_single got=%b exp=0", s_udf); end
        // write + read at count 0: read rejected
        we = 1'b1; re = 1'b1; din = 8'h99;
        step();
        checks++; if (s_count !== 5'd1) begin errors++; $display("FAIL empty_rw_count got=%0d exp=1", s_count); end
        checks++; if (s_empty !== 1'b0) begin errors++; $display("FAIL empty_rw_empty got=%b exp=0", s_empty); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL empty_rw_valid got=%b exp=0", s_valid); end
        // read + write at count 1: no empty glitch
        we = 1'b1; re = 1'b1; din = 8'h22;
        step();
        checks++; if (s_count !== 5'd1 || s_empty !== 1'b0) begin errors++; $display("FAIL one_rw got=%0d/%b exp=1/0", s_count, s_empty); end
        checks++; if (s_dout !== 8'h99) begin errors++; $display("FAIL one_rw_data got=%h exp=99", s_dout); end
        we = 1'b0; re = 1'b1;
        step();
        checks++; if (s_dout !== 8'h22 || s_count !== 5'd0) begin errors++; $display("FAIL one_rw_tail got=%h/%0d exp=22/0", s_dout, s_count); end
        idle();
        step();
    endtask

    task automatic test_fwft();
        clear = 1'b1;
        step();
        idle();
        we = 1'b1; din = 8'hA5;
        step();
        checks++; if (f_dout !== 8'hA5)  begin errors++; $display("FAIL fwft_data got=%h exp=a5", f_dout); end
        checks++; if (f_valid !== 1'b1)  begin errors++; $display("FAIL fwft_valid got=%b exp=1", f_valid); end
        we = 1'b0;
        step();
        checks++; if (f_dout !== 8'hA5 || f_count !== 5'd1) begin errors++; $display("FAIL fwft_hold got=%h/%0d exp=a5/1", f_dout, f_count); end
        re = 1'b1;
        step();
        checks++; if (f_empty !== 1'b1 || f_valid !== 1'b0) begin errors++; $display("FAIL fwft_pop got=%b/%b exp=1/0", f_empty, f_valid); end
        re = 1'b0; we = 1'b1; din = 8'h5A;
        step();
        din = 8'h6B;
        step();
        we = 1'b0;
        checks++; if (f_dout !== 8'h5A) begin errors++; $display("FAIL fwft_head got=%h exp=5a", f_dout); end
        re = 1'b1;
        step();
        checks++; if (f_dout !== 8'h6B || f_count !== 5'd1) begin errors++; $display("FAIL fwft_next got=%h/%0d exp=6b/1", f_dout, f_count); end
        idle();
        step();
    endtask

    task automatic test_clear();
        clear = 1'b1;
        step();
        idle();
        for (int i = 0; i < 9; i++) begin
            we = 1'b1; din = 8'(8'h30 + i);
            step();
        end
        checks++; if (s_count !== 5'd9) begin errors++; $display("FAIL clr_pre got=%0d exp=9", s_count); end
        clear = 1'b1; we = 1'b1; re = 1'b1; din = 8'hFF;
        step();
        checks++; if (s_count !== 5'd0 || s_empty !== 1'b1) begin errors++; $display("FAIL clr_count got=%0d/%b exp=0/1", s_count, s_empty); end
        checks++; if ({s_ovf, s_udf, s_valid} !== 3'b000) begin errors++; $display("FAIL clr_pulses got=%b exp=000", {s_ovf, s_udf, s_valid}); end
        checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL clr_dout got=%h exp=00", s_dout); end
        idle();
        we = 1'b1; din = 8'h3C;
        step();
        we = 1'b0; re = 1'b1;
        step();
        checks++; if (s_dout !== 8'h3C || s_valid !== 1'b1) begin errors++; $display("FAIL clr_after got=%h/%b exp=3c/1", s_dout, s_valid); end
        idle();
        step();
    endtask

    initial begin
        clear = 1'b1; we = 1'b0; re = 1'b0; din = 8'h00;
        #1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_underflow();
        test_fwft();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
